// File: rtl/xgmii_64b66b_encoder.sv
// XGMII to 64b/66b block encoder with TX framing check.
// Illegal beats are replaced by error blocks and tallied in a saturating counter.
module xgmii_64b66b_encoder #(
    parameter int ERR_CNT_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     i_rst,
    input  logic                     i_valid,
    input  logic [63:0]              i_txd,
    input  logic [7:0]               i_txc,
    output logic                     o_valid,
    output logic [65:0]              o_block,
    output logic [ERR_CNT_WIDTH-1:0] o_err_count
);

    localparam logic [65:0] IDLE_BLK = {56'h0, 8'h1E, 2'b01};
    localparam logic [65:0] ERR_BLK  = {{8{7'h1E}}, 8'h1E, 2'b01};

    typedef enum logic [1:0] {ST_INIT = 2'd0, ST_C = 2'd1, ST_D = 2'd2} state_e;
    typedef enum logic [2:0] {
        BEAT_C = 3'd0, BEAT_S0 = 3'd1, BEAT_S4 = 3'd2,
        BEAT_D = 3'd3, BEAT_T = 3'd4, BEAT_E = 3'd5
    } beat_e;

    function automatic logic is_idle_err(input logic [7:0] ch);
        return (ch == 8'h07) || (ch == 8'hFE);
    endfunction

    function automatic logic [6:0] ctrl_code(input logic [7:0] ch);
        return (ch == 8'hFE) ? 7'h1E : 7'h00;
    endfunction

    // Terminate in lane k: control mask from lane k upward, FD in lane k, idle/error above it.
    function automatic logic is_term(input logic [63:0] txd, input logic [7:0] txc, input int k);
        logic [7:0] mask;
        logic       ok;
        mask = 8'hFF << k;
        ok   = (txc == mask) && (txd[8*k +: 8] == 8'hFD);
        for (int j = 0; j < 8; j++) begin
            if (j > k && !is_idle_err(txd[8*j +: 8])) ok = 1'b0;
        end
        return ok;
    endfunction

    function automatic logic [7:0] term_type(input logic [2:0] k);
        case (k)
            3'd0:    return 8'h87;
            3'd1:    return 8'h99;
            3'd2:    return 8'hAA;
            3'd3:    return 8'hB4;
            3'd4:    return 8'hCC;
            3'd5:    return 8'hD2;
            3'd6:    return 8'hE1;
            default: return 8'hFF;
        endcase
    endfunction

    state_e                   state_r, state_nx_s;
    beat_e                    beat_s;
    logic [2:0]               t_lane_s;
    logic                     t_found_s;
    logic                     c_ok_s;
    logic [55:0]              codes_s;
    logic [55:0]              low_mask_s, high_mask_s;
    logic [65:0]              enc_s, blk_nx_s;
    logic                     err_s;
    logic                     valid_r;
    logic [65:0]              block_r;
    logic [ERR_CNT_WIDTH-1:0] err_cnt_r;

    // Classify the incoming beat and precompute per-lane 7-bit control codes.
    always_comb begin
        c_ok_s    = (i_txc == 8'hFF);
        codes_s   = 56'h0;
        t_found_s = 1'b0;
        t_lane_s  = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (!is_idle_err(i_txd[8*i +: 8])) c_ok_s = 1'b0;
            codes_s[7*i +: 7] = ctrl_code(i_txd[8*i +: 8]);
            if (is_term(i_txd, i_txc, i)) begin
                t_found_s = 1'b1;
                t_lane_s  = 3'(i);
            end
        end
        if (c_ok_s) begin
            beat_s = BEAT_C;
        end else if (i_txc == 8'h01 && i_txd[7:0] == 8'hFB) begin
            beat_s = BEAT_S0;
        end else if (i_txc == 8'h1F && i_txd[39:32] == 8'hFB &&
                     is_idle_err(i_txd[7:0]) && is_idle_err(i_txd[15:8]) &&
                     is_idle_err(i_txd[23:16]) && is_idle_err(i_txd[31:24])) begin
            beat_s = BEAT_S4;
        end else if (i_txc == 8'h00) begin
            beat_s = BEAT_D;
        end else if (t_found_s) begin
            beat_s = BEAT_T;
        end else begin
            beat_s = BEAT_E;
        end
    end

    // Build the candidate block; terminate blocks keep data below lane k and codes above it.
    always_comb begin
        low_mask_s  = (56'h1 << (8 * int'(t_lane_s))) - 56'h1;
        high_mask_s = ~((56'h1 << (7 * (int'(t_lane_s) + 1))) - 56'h1);
        case (beat_s)
            BEAT_C:  enc_s = {codes_s, 8'h1E, 2'b01};
            BEAT_S0: enc_s = {i_txd[63:8], 8'h78, 2'b01};
            BEAT_S4: enc_s = {i_txd[63:40], 4'h0, codes_s[27:0], 8'h33, 2'b01};
            BEAT_D:  enc_s = {i_txd, 2'b10};
            BEAT_T:  enc_s = {(i_txd[55:0] & low_mask_s) | (codes_s & high_mask_s),
                              term_type(t_lane_s), 2'b01};
            default: enc_s = ERR_BLK;
        endcase
    end

    // Framing state machine: decides between the encoded block and an error substitution.
    always_comb begin
        state_nx_s = state_r;
        blk_nx_s   = ERR_BLK;
        err_s      = 1'b0;
        case (state_r)
            ST_INIT, ST_C: begin
                case (beat_s)
                    BEAT_C:           begin blk_nx_s = enc_s; state_nx_s = ST_C; end
                    BEAT_S0, BEAT_S4: begin blk_nx_s = enc_s; state_nx_s = ST_D; end
                    default:          begin err_s = 1'b1;     state_nx_s = ST_C; end
                endcase
            end
            ST_D: begin
                case (beat_s)
                    BEAT_D:  begin blk_nx_s = enc_s; state_nx_s = ST_D; end
                    BEAT_T:  begin blk_nx_s = enc_s; state_nx_s = ST_C; end
                    default: begin err_s = 1'b1;     state_nx_s = ST_C; end
                endcase
            end
            default: begin
                err_s      = 1'b1;
                state_nx_s = ST_INIT;
            end
        endcase
        if (!i_valid) begin
            state_nx_s = state_r;
            err_s      = 1'b0;
        end else begin
            state_nx_s = state_nx_s;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (i_rst) state_r <= ST_INIT;
        else       state_r <= state_nx_s;
    end

    // Output registers and saturating error counter.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            valid_r   <= 1'b0;
            block_r   <= IDLE_BLK;
            err_cnt_r <= '0;
        end else begin
            valid_r <= i_valid;
            if (i_valid) block_r <= blk_nx_s;
            if (err_s && err_cnt_r != {ERR_CNT_WIDTH{1'b1}})
                err_cnt_r <= err_cnt_r + ERR_CNT_WIDTH'(1);
        end
    end

    assign o_valid     = valid_r;
    assign o_block     = block_r;
    assign o_err_count = err_cnt_r;

endmodule

// File: tb/tb_xgmii_64b66b_encoder.sv
// Scoreboard bench for xgmii_64b66b_encoder: a bit-stream reference model queues expected
// blocks; a monitor compares whenever the DUT presents a block. A 2-bit counter copy checks saturation.
module tb_xgmii_64b66b_encoder;

    localparam logic [65:0] IDLE_BLK = {56'h0, 8'h1E, 2'b01};

    typedef struct {
        logic [65:0] blk;
        logic [15:0] cnt;
        logic [1:0]  cnt2;
    } exp_t;

    logic        clk = 1'b0;
    logic        i_rst, i_valid;
    logic [63:0] i_txd;
    logic [7:0]  i_txc;
    logic        o_valid, o_valid2;
    logic [65:0] o_block, o_block2;
    logic [15:0] o_err_count;
    logic [1:0]  o_err_count2;

    exp_t        exp_q[$];
    int          n_cmp = 0;
    int          n_mis = 0;
    bit          m_fr = 1'b0;
    int          m_cnt = 0;
    logic        rst_q = 1'b1;
    logic [65:0] last_blk = IDLE_BLK;
    logic [15:0] last_cnt = 16'h0;

    xgmii_64b66b_encoder #(.ERR_CNT_WIDTH(16)) dut (
        .clk(clk), .i_rst(i_rst), .i_valid(i_valid), .i_txd(i_txd), .i_txc(i_txc),
        .o_valid(o_valid), .o_block(o_block), .o_err_count(o_err_count));

    xgmii_64b66b_encoder #(.ERR_CNT_WIDTH(2)) dut2 (
        .clk(clk), .i_rst(i_rst), .i_valid(i_valid), .i_txd(i_txd), .i_txc(i_txc),
        .o_valid(o_valid2), .o_block(o_block2), .o_err_count(o_err_count2));

    always #5 clk = ~clk;

    function automatic bit ie(input logic [7:0] b);
        return (b == 8'h07) || (b == 8'hFE);
    endfunction

    function automatic logic [7:0] cc(input logic [7:0] b);
        return (b == 8'hFE) ? 8'h1E : 8'h00;
    endfunction

    function automatic void pushv(ref bit q[$], input logic [7:0] v, input int w);
        for (int b = 0; b < w; b++) q.push_back(v[b]);
    endfunction

    // Reference: classify by the lane rules, then serialize fields LSB-first into a bit stream.
    function automatic void model_beat(input logic [63:0] d, input logic [7:0] c,
                                       inout bit fr, output logic [65:0] blk, output bit err);
        logic [7:0] ln [8];
        logic [7:0] ttype [8];
        bit q[$];
        bit c_all, s0, s4, dd, tt, ok;
        int k;
        ttype = '{8'h87, 8'h99, 8'hAA, 8'hB4, 8'hCC, 8'hD2, 8'hE1, 8'hFF};
        for (int i = 0; i < 8; i++) ln[i] = d[8*i +: 8];
        c_all = (c == 8'hFF);
        for (int i = 0; i < 8; i++) if (!ie(ln[i])) c_all = 1'b0;
        s0 = (c == 8'h01) && (ln[0] == 8'hFB);
        s4 = (c == 8'h1F) && (ln[4] == 8'hFB) && ie(ln[0]) && ie(ln[1]) && ie(ln[2]) && ie(ln[3]);
        dd = (c == 8'h00);
        k = 0;
        while (k < 8 && c[k] == 1'b0) k++;
        tt = (k < 8);
        if (tt) tt = (ln[k] == 8'hFD);
        for (int b = 0; b < 8; b++) if (c[b] != (b >= k)) tt = 1'b0;
        for (int j = k + 1; j < 8; j++) if (!ie(ln[j])) tt = 1'b0;
        ok  = fr ? (dd || tt) : (c_all || s0 || s4);
        err = !ok;
        if (!ok) begin
            pushv(q, 8'h01, 2); pushv(q, 8'h1E, 8);
            for (int j = 0; j < 8; j++) pushv(q, 8'h1E, 7);
            fr = 1'b0;
        end else if (dd) begin
            pushv(q, 8'h02, 2);
            for (int i = 0; i < 8; i++) pushv(q, ln[i], 8);
        end else begin
            pushv(q, 8'h01, 2);
            if (c_all) begin
                pushv(q, 8'h1E, 8);
                for (int j = 0; j < 8; j++) pushv(q, cc(ln[j]), 7);
            end else if (s0) begin
                pushv(q, 8'h78, 8);
                for (int i = 1; i < 8; i++) pushv(q, ln[i], 8);
            end else if (s4) begin
                pushv(q, 8'h33, 8);
                for (int j = 0; j < 4; j++) pushv(q, cc(ln[j]), 7);
                pushv(q, 8'h00, 4);
                for (int i = 5; i < 8; i++) pushv(q, ln[i], 8);
            end else begin
                pushv(q, ttype[k], 8);
                for (int i = 0; i < k; i++) pushv(q, ln[i], 8);
                pushv(q, 8'h00, 7 - k);
                for (int j = k + 1; j < 8; j++) pushv(q, cc(ln[j]), 7);
            end
            fr = s0 || s4;
        end
        blk = '0;
        for (int i = 0; i < 66 && i < q.size(); i++) blk[i] = q[i];
    endfunction

    task automatic check(input string name, input logic [65:0] act, input logic [65:0] req);
        n_cmp++;
        if (act !== req) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic beat(input logic [63:0] d, input logic [7:0] c, input logic v);
        logic [65:0] blk;
        bit err;
        exp_t e;
        @(negedge clk);
        i_txd = d; i_txc = c; i_valid = v;
        if (v) begin
            model_beat(d, c, m_fr, blk, err);
            if (err && m_cnt < 65535) m_cnt++;
            e.blk  = blk;
            e.cnt  = 16'(m_cnt);
            e.cnt2 = (m_cnt > 3) ? 2'd3 : 2'(m_cnt);
            exp_q.push_back(e);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        i_rst = 1'b1; i_valid = 1'b0;
        m_fr = 1'b0; m_cnt = 0;
        @(negedge clk);
        i_rst = 1'b0;
    endtask

    task automatic rand_beat();
        logic [63:0] d;
        logic [7:0]  c;
        int k;
        d = {$urandom, $urandom};
        c = 8'h00;
        case ($urandom_range(0, 7))
            0: begin
                c = 8'hFF;
                for (int i = 0; i < 8; i++) d[8*i +: 8] = ($urandom_range(0, 3) == 0) ? 8'hFE : 8'h07;
            end
            1: begin c = 8'h01; d[7:0] = 8'hFB; end
            2: begin
                c = 8'h1F; d[39:32] = 8'hFB;
                for (int i = 0; i < 4; i++) d[8*i +: 8] = ($urandom_range(0, 3) == 0) ? 8'hFE : 8'h07;
            end
            3, 4: c = 8'h00;
            5, 6: begin
                k = $urandom_range(0, 7);
                c = 8'(8'hFF << k);
                d[8*k +: 8] = 8'hFD;
                for (int j = k + 1; j < 8; j++) d[8*j +: 8] = ($urandom_range(0, 3) == 0) ? 8'hFE : 8'h07;
            end
            default: c = 8'($urandom);
        endcase
        beat(d, c, ($urandom_range(0, 4) != 0));
    endtask

    always @(posedge clk) rst_q <= i_rst;

    // Monitor: pop and compare on every presented block; during gaps the block must hold.
    always @(negedge clk) begin
        exp_t e;
        if (rst_q) begin
            last_blk = IDLE_BLK;
            last_cnt = 16'h0;
        end else if (o_valid) begin
            if (exp_q.size() == 0) begin
                n_cmp++; n_mis++;
                $display("FAIL unexpected_block: got %h expected none", o_block);
            end else begin
                e = exp_q.pop_front();
                check("block", o_block, e.blk);
                check("err_count", 66'(o_err_count), 66'(e.cnt));
                check("err_count_sat", 66'(o_err_count2), 66'(e.cnt2));
                last_blk = e.blk;
                last_cnt = e.cnt;
            end
        end else begin
            check("hold_block", o_block, last_blk);
            check("hold_err_count", 66'(o_err_count), 66'(last_cnt));
        end
    end

    initial begin
        i_rst = 1'b1; i_valid = 1'b0; i_txd = 64'h0; i_txc = 8'h00;
        repeat (2) @(negedge clk);
        check("reset_valid", 66'(o_valid), 66'(1'b0));
        check("reset_block", o_block, IDLE_BLK);
        check("reset_err_count", 66'(o_err_count), 66'h0);
        i_rst = 1'b0;

        repeat (3) beat({8{8'h07}}, 8'hFF, 1'b1);
        beat(64'hD5555555555555FB, 8'h01, 1'b1);
        beat(64'h0123456789ABCDEF, 8'h00, 1'b1);
        beat(64'h07070707FD332211, 8'hF8, 1'b1);
        beat(64'hA1B2C3FB07070707, 8'h1F, 1'b1);
        beat(64'h07070707070707FD, 8'hFF, 1'b1);
        beat(64'h1111111111111111, 8'h00, 1'b1);
        beat(64'hD5555555555555FB, 8'h01, 1'b1);
        beat(64'hD5555555555555FB, 8'h01, 1'b1);
        beat(64'h07070707FE070707, 8'h0F, 1'b1);
        beat(64'hD5555555555555FB, 8'h01, 1'b1);
        beat(64'h2222222222222222, 8'h00, 1'b0);
        beat(64'h3333333333333333, 8'h00, 1'b1);
        beat(64'h070707FD44444444, 8'hF0, 1'b1);
        beat(64'hD5555555555555FB, 8'h01, 1'b1);
        beat(64'h5555555555555555, 8'h00, 1'b1);
        beat(64'hFE07FE07FE07FE07, 8'hFF, 1'b1);
        beat(64'h6666666666666666, 8'h00, 1'b1);
        beat(64'hD5555555555555FB, 8'h01, 1'b1);
        beat(64'h7777777777777777, 8'h00, 1'b1);
        do_reset();
        beat(64'h8888888888888888, 8'h00, 1'b1);
        beat({8{8'h07}}, 8'hFF, 1'b1);

        for (int n = 0; n < 400; n++) rand_beat();

        for (int n = 0; n < 10 && exp_q.size() != 0; n++) beat(64'h0, 8'h00, 1'b0);
        beat(64'h0, 8'h00, 1'b0);
        check("queue_drained", 66'(exp_q.size()), 66'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
